// File: rtl/oled_serial_responder.sv
// oled_serial_responder
//   Byte-level responder for an SSD1306-style serial display protocol. It sits
//   behind an I2C/SPI bus receiver and in front of a page-organised framebuffer.
//   It does three things:
//     - parses control, command and data bytes;
//     - keeps the display configuration registers;
//     - turns pixel bytes into framebuffer writes, using horizontal-mode
//       address auto-increment.
//
// Ports
//   in_clk, in_rst                  clock, asynchronous active-low reset
//   in_bus_start / in_bus_stop      1-cycle transaction delimiters
//   in_bus_valid, in_bus_data       1-cycle received-byte strobe and byte
//   out_fb_we/col/page/data         registered framebuffer write
//   out_frame_done                  pulses with the write that wraps the window
//   out_disp_on, out_all_on, out_invert, out_remap_h, out_remap_v
//                                   display mode flags
//   out_contrast, out_start_line    display registers
//   out_cmd_err                     sticky: unknown opcode or non-horizontal mode
module oled_serial_responder #(
  parameter int SCREEN_WIDTH  = 128,
  parameter int SCREEN_HEIGHT = 64,
  parameter int BUS_BITS      = 8,
  parameter int SCREEN_PAGES  = SCREEN_HEIGHT / BUS_BITS,
  parameter int HCTR_BITS     = $clog2(SCREEN_WIDTH),
  parameter int PAGE_BITS     = $clog2(SCREEN_PAGES)
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_bus_start,
  input  logic                 in_bus_stop,
  input  logic                 in_bus_valid,
  input  logic [BUS_BITS-1:0]  in_bus_data,
  output logic                 out_fb_we,
  output logic [HCTR_BITS-1:0] out_fb_col,
  output logic [PAGE_BITS-1:0] out_fb_page,
  output logic [BUS_BITS-1:0]  out_fb_data,
  output logic                 out_frame_done,
  output logic                 out_disp_on,
  output logic                 out_all_on,
  output logic                 out_invert,
  output logic                 out_remap_h,
  output logic                 out_remap_v,
  output logic [7:0]           out_contrast,
  output logic [5:0]           out_start_line,
  output logic                 out_cmd_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CTRL = 2'd1,
    S_CMD  = 2'd2,
    S_DATA = 2'd3
  } state_t;

  state_t               state_r;
  state_t               eff_state_s;
  logic                 single_r;      // Co=1: one byte only, then back to control
  logic [1:0]           args_left_r;
  logic [1:0]           eff_args_s;
  logic [7:0]           opcode_r;
  logic [HCTR_BITS-1:0] arg1_r;        // first argument of a two-argument opcode
  logic [HCTR_BITS-1:0] col_r, col_start_r, col_end_r;
  logic [PAGE_BITS-1:0] page_r, page_start_r, page_end_r;

  // Context for the current byte. A start pulse makes it a control byte and
  // drops any half-received command.
  always_comb begin
    eff_state_s = state_r;
    eff_args_s  = args_left_r;
    if (in_bus_start) begin
      eff_state_s = S_CTRL;
      eff_args_s  = 2'd0;
    end else begin
      eff_state_s = state_r;
      eff_args_s  = args_left_r;
    end
  end

  // Protocol FSM, register file, address generator and framebuffer write port.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_r        <= S_IDLE;
      single_r       <= 1'b0;
      args_left_r    <= 2'd0;
      opcode_r       <= 8'h00;
      arg1_r         <= '0;
      col_r          <= '0;
      col_start_r    <= '0;
      col_end_r      <= HCTR_BITS'(SCREEN_WIDTH - 1);
      page_r         <= '0;
      page_start_r   <= '0;
      page_end_r     <= PAGE_BITS'(SCREEN_PAGES - 1);
      out_fb_we      <= 1'b0;
      out_fb_col     <= '0;
      out_fb_page    <= '0;
      out_fb_data    <= '0;
      out_frame_done <= 1'b0;
      out_disp_on    <= 1'b0;
      out_all_on     <= 1'b0;
      out_invert     <= 1'b0;
      out_remap_h    <= 1'b0;
      out_remap_v    <= 1'b0;
      out_contrast   <= 8'h7F;
      out_start_line <= 6'd0;
      out_cmd_err    <= 1'b0;
    end else begin
      out_fb_we      <= 1'b0;
      out_frame_done <= 1'b0;
      state_r        <= eff_state_s;
      args_left_r    <= eff_args_s;

      if (in_bus_valid) begin
        case (eff_state_s)
          S_CTRL: begin
            single_r <= in_bus_data[BUS_BITS-1];
            state_r  <= in_bus_data[BUS_BITS-2] ? S_DATA : S_CMD;
          end

          S_CMD: begin
            if (single_r) state_r <= S_CTRL;
            if (eff_args_s != 2'd0) begin
              // Argument byte for the opcode latched earlier.
              args_left_r <= eff_args_s - 2'd1;
              case (opcode_r)
                8'h20: begin
                  if (in_bus_data != 8'h00) out_cmd_err <= 1'b1;
                end
                8'h81: out_contrast <= in_bus_data;
                8'h21: begin
                  if (eff_args_s == 2'd2) begin
                    arg1_r <= in_bus_data[HCTR_BITS-1:0];
                  end else begin
                    col_start_r <= arg1_r;
                    col_end_r   <= in_bus_data[HCTR_BITS-1:0];
                    col_r       <= arg1_r;
                  end
                end
                8'h22: begin
                  if (eff_args_s == 2'd2) begin
                    arg1_r <= in_bus_data[HCTR_BITS-1:0];
                  end else begin
                    page_start_r <= arg1_r[PAGE_BITS-1:0];
                    page_end_r   <= in_bus_data[PAGE_BITS-1:0];
                    page_r       <= arg1_r[PAGE_BITS-1:0];
                  end
                end
                default: ;  // accepted and discarded
              endcase
            end else begin
              opcode_r <= in_bus_data;
              casez (in_bus_data)
                8'b000?_????:        ;  // 0x00-0x1F ignored
                8'b01??_????:        out_start_line <= in_bus_data[5:0];
                8'hA0, 8'hA1:        out_remap_h <= in_bus_data[0];
                8'hA4, 8'hA5:        out_all_on  <= in_bus_data[0];
                8'hA6, 8'hA7:        out_invert  <= in_bus_data[0];
                8'hAE, 8'hAF:        out_disp_on <= in_bus_data[0];
                8'hC0, 8'hC8:        out_remap_v <= in_bus_data[3];
                8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
                8'hD5, 8'hD9, 8'hDA, 8'hDB: args_left_r <= 2'd1;
                8'h21, 8'h22:        args_left_r <= 2'd2;
                default:             out_cmd_err <= 1'b1;
              endcase
            end
          end

          S_DATA: begin
            if (single_r) state_r <= S_CTRL;
            out_fb_we   <= 1'b1;
            out_fb_col  <= col_r;
            out_fb_page <= page_r;
            out_fb_data <= in_bus_data;
            // Horizontal mode; start > end wraps through the field maximum.
            if (col_r == col_end_r) begin
              col_r <= col_start_r;
              if (page_r == page_end_r) begin
                page_r         <= page_start_r;
                out_frame_done <= 1'b1;
              end else begin
                page_r <= page_r + PAGE_BITS'(1);
              end
            end else begin
              col_r <= col_r + HCTR_BITS'(1);
            end
          end

          default: ;  // bytes outside a transaction are ignored
        endcase
      end

      // A stop is applied after any byte that arrives in the same cycle.
      if (in_bus_stop) begin
        state_r     <= S_IDLE;
        args_left_r <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_oled_serial_responder.sv
// tb_oled_serial_responder
//   Directed bench for oled_serial_responder. It has two parts:
//     - a vector table that covers the address-window walk, including the
//       simultaneous start/stop edge cases;
//     - hand-written sequences for init, full frame, split arguments with
//       abort, errors and reset mid-stream.
module tb_oled_serial_responder;

  logic       clk;
  logic       rst;
  logic       bus_start, bus_stop, bus_valid;
  logic [7:0] bus_data;
  logic       fb_we;
  logic [6:0] fb_col;
  logic [2:0] fb_page;
  logic [7:0] fb_data;
  logic       frame_done;
  logic       disp_on, all_on, invert, remap_h, remap_v;
  logic [7:0] contrast;
  logic [5:0] start_line;
  logic       cmd_err;

  int checks   = 0;
  int failures = 0;

  oled_serial_responder dut (
    .in_clk        (clk),
    .in_rst        (rst),
    .in_bus_start  (bus_start),
    .in_bus_stop   (bus_stop),
    .in_bus_valid  (bus_valid),
    .in_bus_data   (bus_data),
    .out_fb_we     (fb_we),
    .out_fb_col    (fb_col),
    .out_fb_page   (fb_page),
    .out_fb_data   (fb_data),
    .out_frame_done(frame_done),
    .out_disp_on   (disp_on),
    .out_all_on    (all_on),
    .out_invert    (invert),
    .out_remap_h   (remap_h),
    .out_remap_v   (remap_v),
    .out_contrast  (contrast),
    .out_start_line(start_line),
    .out_cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start, stop, valid;
    logic [7:0] data;
    logic       we;
    logic [2:0] page;
    logic [6:0] col;
    logic [7:0] wdata;
    logic       fd;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of bus inputs and sample the registered response.
  task automatic send(input logic s, input logic p, input logic v, input logic [7:0] d);
    bus_start = s; bus_stop = p; bus_valid = v; bus_data = d;
    @(posedge clk); #1;
    bus_start = 1'b0; bus_stop = 1'b0; bus_valid = 1'b0; bus_data = 8'h00;
  endtask

  task automatic put(input logic [7:0] d);
    send(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic tstart();
    send(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic tstop();
    send(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_we"}, {31'd0, fb_we}, 32'd0);
    chk({tag, "_fbaddr"}, {14'd0, fb_page, fb_col, fb_data}, 32'd0);
    chk({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_flags"}, {26'd0, disp_on, all_on, invert, remap_h, remap_v, cmd_err}, 32'd0);
    chk({tag, "_contrast"}, {24'd0, contrast}, 32'h7F);
    chk({tag, "_start_line"}, {26'd0, start_line}, 32'd0);
  endtask

  initial begin
    int bad;
    int fd_cnt;
    clk = 1'b0; rst = 1'b0;
    bus_start = 1'b0; bus_stop = 1'b0; bus_valid = 1'b0; bus_data = 8'h00;

    // Window walk: cols 16..17, pages 2..3, five data bytes.
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 7'd0,  8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h21, 1'b0, 3'd0, 7'd0,  8'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 3'd0, 7'd0,  8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 3'd0, 7'd0,  8'h00, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 3'd0, 7'd0,  8'h00, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 3'd0, 7'd0,  8'h00, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 3'd0, 7'd0,  8'h00, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 7'd0,  8'h00, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 3'd0, 7'd0,  8'h00, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 3'd2, 7'd16, 8'hA1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'hA2, 1'b1, 3'd2, 7'd17, 8'hA2, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'hA3, 1'b1, 3'd3, 7'd16, 8'hA3, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'hA4, 1'b1, 3'd3, 7'd17, 8'hA4, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 3'd2, 7'd16, 8'hA5, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 3'd0, 7'd0,  8'h00, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 7'd0,  8'h00, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;

    // Init sequence, one transaction per group.
    tstart(); put(8'h80); put(8'hAE); tstop();
    tstart(); put(8'h00); put(8'hD5); put(8'hF0); put(8'h81); put(8'hFF); tstop();
    tstart(); put(8'h80); put(8'hA1); tstop();
    tstart(); put(8'h80); put(8'hC8); tstop();
    tstart(); put(8'h80); put(8'hAF); tstop();
    chk("init_disp_on",  {31'd0, disp_on}, 32'd1);
    chk("init_contrast", {24'd0, contrast}, 32'hFF);
    chk("init_remap_h",  {31'd0, remap_h}, 32'd1);
    chk("init_remap_v",  {31'd0, remap_v}, 32'd1);
    chk("init_cmd_err",  {31'd0, cmd_err}, 32'd0);

    // Horizontal mode with argument 0x00 is legal; start line command.
    tstart(); put(8'h00); put(8'h20); put(8'h00); put(8'h4A); tstop();
    chk("hmode_ok_err",  {31'd0, cmd_err}, 32'd0);
    chk("start_line",    {26'd0, start_line}, 32'h0A);

    // Table-driven address window.
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].start, vecs[i].stop, vecs[i].valid, vecs[i].data);
      if (vecs[i].we)
        chk($sformatf("win_vec%0d", i), {13'd0, fb_we, fb_page, fb_col, fb_data, frame_done},
            {13'd0, 1'b1, vecs[i].page, vecs[i].col, vecs[i].wdata, vecs[i].fd});
      else
        chk($sformatf("win_vec%0d", i), {30'd0, fb_we, frame_done}, 32'd0);
    end

    // Full frame over default windows, back-to-back data.
    tstart(); put(8'h00); put(8'h21); put(8'h00); put(8'h7F);
    put(8'h22); put(8'h00); put(8'h07); tstop();
    tstart(); put(8'h40);
    bad = 0; fd_cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      put(i[7:0]);
      if (!(fb_we === 1'b1 && fb_page == 3'(i / 128) && fb_col == 7'(i % 128) && fb_data == i[7:0]))
        bad++;
      if (frame_done === 1'b1) fd_cnt++;
    end
    chk("frame_addr_errors", bad, 32'd0);
    chk("frame_done_count", fd_cnt, 32'd1);
    chk("frame_last", {22'd0, fb_page, fb_col}, {22'd0, 3'd7, 7'd127});
    send(1'b0, 1'b1, 1'b1, 8'h99);
    chk("frame_wrap", {14'd0, fb_we, fb_page, fb_col, fb_data}, {14'd0, 1'b1, 3'd0, 7'd0, 8'h99});

    // Split arguments across Co=1 pairs, then an aborted window command.
    tstart(); put(8'h80); put(8'h81); put(8'h80); put(8'h20); tstop();
    chk("split_contrast", {24'd0, contrast}, 32'h20);
    tstart(); put(8'h00); put(8'h21); put(8'h05); tstop();
    tstart(); put(8'hC0); put(8'h77);
    chk("abort_data_ptr", {14'd0, fb_we, fb_page, fb_col, fb_data}, {14'd0, 1'b1, 3'd0, 7'd1, 8'h77});
    put(8'h80); put(8'hA7); tstop();
    chk("abort_args_cleared", {31'd0, invert}, 32'd1);

    // Errors: unknown opcode, unsupported mode, then normal parsing resumes.
    tstart(); put(8'h00); put(8'hE3);
    chk("err_unknown", {31'd0, cmd_err}, 32'd1);
    put(8'h20); put(8'h01); tstop();
    tstart(); put(8'h00); put(8'hA6); put(8'h81); put(8'h33); tstop();
    chk("err_sticky", {31'd0, cmd_err}, 32'd1);
    chk("err_parse_contrast", {24'd0, contrast}, 32'h33);
    chk("err_parse_invert", {31'd0, invert}, 32'd0);

    // Reset asserted mid-burst.
    tstart(); put(8'h40); put(8'h11); put(8'h22);
    chk("burst_we_before_rst", {31'd0, fb_we}, 32'd1);
    bus_valid = 1'b1; bus_data = 8'h33;
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clk); #1;
    chk("midrst_no_write", {31'd0, fb_we}, 32'd0);
    bus_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_we", {31'd0, fb_we}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oled_serial_responder.md
# oled_serial_responder

Byte-level responder for the SSD1306-style serial display protocol: decodes the control/command/data byte stream from a bus receiver front end (I2C or SPI responder), tracks display configuration registers, and turns pixel data bytes into framebuffer writes with horizontal-mode address auto-increment. It sits behind the bus receiver and in front of a page-organised framebuffer RAM. It serves as a display emulator for verifying display drivers and as a drop-in target for screen mirroring.

## Interface
- `SCREEN_WIDTH`, 128, columns.
- `SCREEN_HEIGHT`, 64, pixel rows.
- `BUS_BITS`, 8, byte width; one framebuffer word is one page column of `BUS_BITS` pixels.
- `SCREEN_PAGES`, `SCREEN_HEIGHT / BUS_BITS`, pages.
- `HCTR_BITS`, `$clog2(SCREEN_WIDTH)`; `PAGE_BITS`, `$clog2(SCREEN_PAGES)`.

Ports:
- `in_clk`  input  1  system clock; one clock; all logic on the rising edge.
- `in_rst`  input  1  reset, asynchronous and active-low.
- `in_bus_start`  input  1  1-cycle pulse: a new bus transaction begins.
- `in_bus_stop`  input  1  1-cycle pulse: the transaction ends.
- `in_bus_valid`  input  1  1-cycle pulse: `in_bus_data` holds a received byte.
- `in_bus_data`  input  `BUS_BITS`  received byte.
- `out_fb_we`  output  1  framebuffer write strobe.
- `out_fb_col`  output  `HCTR_BITS`  write column.
- `out_fb_page`  output  `PAGE_BITS`  write page.
- `out_fb_data`  output  `BUS_BITS`  write data; bit 0 is the top pixel of the page.
- `out_frame_done`  output  1  1-cycle pulse when the address wraps from (`page_end`, `col_end`).
- `out_disp_on`, `out_all_on`, `out_invert`, `out_remap_h`, `out_remap_v`  output  1 each  display mode flags.
- `out_contrast`  output  8  contrast register.
- `out_start_line`  output  6  display start line.
- `out_cmd_err`  output  1  sticky flag for an unknown opcode or an unsupported addressing mode.

## Operation
- States:
  - Idle: wait for `in_bus_start`, then go to Control.
  - Control: the next byte is a control byte. Bit 7 is Co and bit 6 is D/C; other bits are ignored.
  - Cmd: expect an opcode or an argument.
  - Data: expect pixel bytes.
- Control byte with Co=1: exactly one following byte is taken as Cmd or Data, selected by D/C, then the FSM returns to Control.
- Control byte with Co=0: all remaining bytes of the transaction are Cmd (D/C=0) or Data (D/C=1).
- Argument counter `args_left`:
  - Loaded when an opcode is decoded.
  - Persists across control bytes, so an opcode and its arguments may be split over several Co=1 pairs.
  - While `args_left`≠0, every Cmd byte is an argument, not an opcode.
- Opcodes with 0 arguments:
  - 0x00–0x1F: ignored.
  - 0x40–0x7F: `start_line` = byte[5:0].
  - 0xA0/A1: `remap_h` = bit 0.
  - 0xA4/A5: `all_on` = bit 0.
  - 0xA6/A7: `invert` = bit 0.
  - 0xAE/AF: `disp_on` = bit 0.
  - 0xC0/C8: `remap_v` = bit 3.
- Opcodes with 1 argument:
  - 0x20: the argument must be 0x00 (horizontal mode); any other value sets `out_cmd_err`.
  - 0x81: contrast.
  - 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB: argument accepted and discarded.
- Opcodes with 2 arguments:
  - 0x21: `col_start`, `col_end`, each truncated to `HCTR_BITS`.
  - 0x22: `page_start`, `page_end`, each truncated to `PAGE_BITS`.
  - When the second argument arrives, the pointer (`col` or `page`) is loaded with the start value.
- Any other opcode: 0 arguments, `out_cmd_err` set.
- Data byte:
  - Write `in_bus_data` at (`page`, `col`).
  - If `col`==`col_end`: `col` ← `col_start` and the page advances.
  - Otherwise `col` ← `col`+1.
- Page advance: if `page`==`page_end`, `page` ← `page_start` and `out_frame_done` pulses; otherwise `page` ← `page`+1.
- Address arithmetic wraps modulo field width. If start > end, the increment continues to the field maximum and wraps to 0 before reaching end.
- `in_bus_stop` or a new `in_bus_start` at any time:
  - The FSM returns to Idle (for stop) or Control (for start).
  - `args_left` is cleared; a partially received command is dropped, with no register update.
  - Address pointers and windows are kept.
- A byte arriving in Idle is ignored.

## Timing
- Reset values:
  - State Idle; all strobes 0; `out_fb_*` all 0.
  - Flags: `disp_on`=0, `all_on`=0, `invert`=0, `remap_h`=0, `remap_v`=0, `cmd_err`=0.
  - `contrast`=0x7F, `start_line`=0.
  - Windows full: columns 0..`SCREEN_WIDTH`-1, pages 0..`SCREEN_PAGES`-1; `col`=0, `page`=0.
- Register updates and the `out_fb_*` write are registered. They appear 1 cycle after the `in_bus_valid` edge, and `out_fb_we` lasts exactly 1 cycle.
- `out_frame_done` coincides with the `out_fb_we` of the wrapping write.
- Simultaneous events:
  - `in_bus_valid` with `in_bus_stop`: the byte is processed first, then the FSM goes to Idle.
  - `in_bus_valid` with `in_bus_start`: the byte is taken as the first control byte.
- Back-to-back `in_bus_valid` on consecutive cycles must be sustained, giving one write per cycle.
- Asserting `in_rst` mid-transaction forces all reset values immediately, with no write in flight.
- `out_cmd_err` clears only on reset.

## Test plan
- Init sequence:
  - Stimulus: start; 0x80,0xAE; 0x00,0xD5,0xF0,0x81,0xFF; 0x80,0xA1; 0x80,0xC8; 0x80,0xAF; stop.
  - Response: `disp_on`=1, `contrast`=0xFF, `remap_h`=1, `remap_v`=1, `cmd_err`=0.
- Address window:
  - Stimulus: 0x00,0x21,0x10,0x11,0x22,0x02,0x03; then 0x40 followed by 5 data bytes.
  - Response: writes at (page,col) (2,16), (2,17), (3,16), (3,17), (2,16). `out_frame_done` pulses with the 4th write.
- Full frame:
  - Stimulus: default windows, 1024 data bytes.
  - Response: the last write is at (7,127), `out_frame_done` pulses once, and the pointer returns to (0,0).
- Split arguments and abort:
  - Stimulus: 0x80,0x81; 0x80,0x20 gives contrast 0x20. Then 0x00,0x21,0x05 followed by stop.
  - Response: the column window is unchanged; the next data byte goes to the previous pointer.
- Errors:
  - Stimulus: opcode 0xE3; then 0x20,0x01.
  - Response: `cmd_err`=1 sticky; the bytes following are still parsed correctly.
- Reset mid-stream:
  - Stimulus: assert `in_rst` during a data burst.
  - Response: no further `out_fb_we`, and all outputs take their reset values the same cycle.
